// File: rtl/alu_issue_unit.sv
// alu_issue_unit: two-state issue/writeback sequencer in front of a
// 4-bit combinational ALU, with a 4x4 register file and sticky flags.
module alu_issue_unit #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_kind,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_rd,
    input  logic [1:0]   cmd_rs1,
    input  logic [1:0]   cmd_rs2,
    input  logic [W-1:0] cmd_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_res,
    input  logic         alu_car,
    input  logic         alu_of,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_car,
    output logic         out_of,
    output logic         car_sticky,
    output logic         of_sticky,
    input  logic         clr_flags,
    input  logic [1:0]   dbg_idx,
    output logic [W-1:0] dbg_data
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t         state;
    logic           kind_q;
    logic [1:0]     rd_q;
    logic [W-1:0]   imm_q;
    logic [W-1:0]   rf [NREG];

    logic [W-1:0]   wb_data;
    logic           wb_car;
    logic           wb_of;
    logic           accept;
    logic           in_exec;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign in_exec   = (state == EXEC);
    assign dbg_data  = rf[dbg_idx];

    // Writeback value: immediate for loads, ALU outputs otherwise.
    always_comb begin
        wb_data = alu_res;
        wb_car  = alu_car;
        wb_of   = alu_of;
        if (kind_q) begin
            wb_data = imm_q;
            wb_car  = 1'b0;
            wb_of   = 1'b0;
        end
    end

    // Issue/writeback FSM, register file and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kind_q     <= 1'b0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_car    <= 1'b0;
            out_of     <= 1'b0;
            car_sticky <= 1'b0;
            of_sticky  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            car_sticky <= (clr_flags ? 1'b0 : car_sticky)
                        | (in_exec & wb_car);
            of_sticky  <= (clr_flags ? 1'b0 : of_sticky)
                        | (in_exec & wb_of);
            unique case (1'b1)
                !in_exec: begin
                    if (accept) begin
                        kind_q <= cmd_kind;
                        rd_q   <= cmd_rd;
                        imm_q  <= cmd_imm;
                        state  <= EXEC;
                        if (!cmd_kind) begin
                            alu_a    <= rf[cmd_rs1];
                            alu_b    <= rf[cmd_rs2];
                            alu_ctrl <= cmd_op;
                        end
                    end
                end
                in_exec: begin
                    rf[rd_q]  <= wb_data;
                    out_data  <= wb_data;
                    out_car   <= wb_car;
                    out_of    <= wb_of;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
